mux4_rr_arbiter: RTL and testbench

//  - Shares one WIDTH-bit output channel among 4 valid/ready requesters.
//  - Grants by round-robin and steers data through a mux4 instance.
//  - Lands the winning beat in a 1-entry registered output buffer.
//  - Sits in front of any single-consumer resource in the datapath (bus, display, memory port).

---
 rtl/mux4_rr_arbiter_pkg.sv | 11 +
 rtl/mux4_rr_arbiter_mux4.sv | 20 ++
 rtl/mux4_rr_arbiter.sv | 108 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and lock-state encoding for the 4-way round-robin arbiter.
package mux4_rr_arbiter_pkg;
    localparam int NUM_REQ = 4;
    localparam int GRANT_W = 2;
    localparam logic [GRANT_W-1:0] GRANT_RESET = 2'd3;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_st_e;
endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// Plain 4:1 data multiplexer, WIDTH bits wide.
module mux4 #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    input  logic [WIDTH-1:0] d3_i,
    output logic [WIDTH-1:0] y_o
);
    always_comb begin
        unique case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter of 4 valid/ready requesters into a 1-entry output buffer.
// Define MUX4_RR_ARBITER_LOCK_EN to hold the grant until a requester's last beat.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req_valid,
    output logic [3:0]         req_ready,
    input  logic [3:0]         req_last,
    input  logic [WIDTH-1:0]   req_data0,
    input  logic [WIDTH-1:0]   req_data1,
    input  logic [WIDTH-1:0]   req_data2,
    input  logic [WIDTH-1:0]   req_data3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [GRANT_W-1:0] grant_id
);
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_last_q;
    logic [GRANT_W-1:0] grant_q;
    logic               can_accept;
    logic               found;
    logic [GRANT_W-1:0] winner;
    logic               xfer;
    logic               locked;
    logic [WIDTH-1:0]   mux_data;

    // Offsets are scanned farthest-first so the nearest valid requester after last wins.
    function automatic logic [GRANT_W:0] rr_pick(input logic [3:0] valid,
                                                 input logic [GRANT_W-1:0] last);
        logic [GRANT_W:0]   r;
        logic [GRANT_W-1:0] idx;
        r = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last + GRANT_W'(k);
            if (valid[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign can_accept = !out_valid_q || out_ready;

    always_comb begin
        {found, winner} = rr_pick(req_valid, grant_q);
        if (locked) begin
            winner = grant_q;
            found  = req_valid[grant_q];
        end
    end

    assign xfer      = found && can_accept && rst_n;
    assign req_ready = xfer ? (4'(1) << winner) : 4'b0000;

`ifdef MUX4_RR_ARBITER_LOCK_EN
    lock_st_e lock_q, lock_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_q <= ST_UNLOCKED;
        else        lock_q <= lock_d;
    end

    // While locked the winner is the lock owner, so one rule covers both transitions.
    always_comb begin
        lock_d = lock_q;
        if (xfer) lock_d = req_last[winner] ? ST_UNLOCKED : ST_LOCKED;
    end

    assign locked = (lock_q == ST_LOCKED);
`else
    assign locked = 1'b0;
`endif

    mux4 #(.WIDTH(WIDTH)) u_mux (
        .sel_i (winner),
        .d0_i  (req_data0),
        .d1_i  (req_data1),
        .d2_i  (req_data2),
        .d3_i  (req_data3),
        .y_o   (mux_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            grant_q     <= GRANT_RESET;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_data;
            out_last_q  <= req_last[winner];
            grant_q     <= winner;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign grant_id  = grant_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter; lock expectations follow MUX4_RR_ARBITER_LOCK_EN.
module tb_mux4_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_valid, req_ready, req_last;
    logic [7:0] d0, d1, d2, d3;
    logic       out_valid, out_ready, out_last;
    logic [7:0] out_data;
    logic [1:0] grant_id;
    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
        .req_data0(d0), .req_data1(d1), .req_data2(d2), .req_data3(d3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; req_last = 4'hF; out_ready = 1'b1;
        d0 = 8'hA0; d1 = 8'hA1; d2 = 8'hA2; d3 = 8'hA3;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b exp 0", out_last); end
        checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL rst_grant got %0d exp 3", grant_id); end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got %b exp 0001", req_ready); end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_d;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_d = 8'hA0 + 8'(i % 4);
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d || grant_id !== 2'(i % 4) || out_last !== 1'b1) begin
                errors++; $display("FAIL fair_beat%0d got v%b d%h g%0d l%b exp v1 d%h g%0d l1",
                                   i, out_valid, out_data, grant_id, out_last, exp_d, i % 4);
            end
        end
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== 8'hA0) begin
            errors++; $display("FAIL fair_drain got v%b d%h exp v0 dA0", out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; req_valid = 4'b0010; d1 = 8'h55;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_accept got %b exp 0010", req_ready); end
        @(negedge clk);
        d1 = 8'h56;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h55 || req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_hold%0d got v%b d%h r%b exp v1 d55 r0000", i, out_valid, out_data, req_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release got %b exp 0010", req_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h56 || grant_id !== 2'd1) begin
            errors++; $display("FAIL bp_next got v%b d%h g%0d exp v1 d56 g1", out_valid, out_data, grant_id);
        end
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_drain_refill();
        out_ready = 1'b0; req_valid = 4'b0100; d2 = 8'hC2;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hC2 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL dr_full got v%b d%h r%b exp v1 dC2 r0000", out_valid, out_data, req_ready);
        end
        d2 = 8'hC3; out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL dr_ready got %b exp 0100", req_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hC3 || grant_id !== 2'd2) begin
            errors++; $display("FAIL dr_refill got v%b d%h g%0d exp v1 dC3 g2", out_valid, out_data, grant_id);
        end
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dr_drain got %b exp 0", out_valid); end
    endtask

    // req0 offers 3 beats (10,11,12, last on 12); req1 offers 2 beats (20,21, last on 21).
    task automatic test_lock();
        logic [7:0] exp_d [5];
        logic [1:0] exp_g [5];
        logic       exp_l [5];
        logic [3:0] hs;
        int b0 = 0;
        int b1 = 0;
`ifdef MUX4_RR_ARBITER_LOCK_EN
        exp_d = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21};
        exp_g = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_d = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12};
        exp_g = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req_valid = {2'b00, b1 < 2, b0 < 3};
            req_last  = {2'b00, b1 == 1, b0 == 2};
            d0 = 8'h10 + 8'(b0);
            d1 = 8'h20 + 8'(b1);
            #1;
            hs = req_valid & req_ready;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d[c] || grant_id !== exp_g[c] || out_last !== exp_l[c]) begin
                errors++; $display("FAIL lock_beat%0d got v%b d%h g%0d l%b exp v1 d%h g%0d l%b",
                                   c, out_valid, out_data, grant_id, out_last, exp_d[c], exp_g[c], exp_l[c]);
            end
            b0 += int'(hs[0]);
            b1 += int'(hs[1]);
        end
        req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; req_valid = 4'b0001; req_last = 4'b0000;
        d0 = 8'h30; d1 = 8'h40;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h30 || grant_id !== 2'd0) begin
            errors++; $display("FAIL mid_pre got v%b d%h g%0d exp v1 d30 g0", out_valid, out_data, grant_id);
        end
        req_valid = 4'b0011; req_last = 4'b0010;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || grant_id !== 2'd3 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_rst got v%b d%h g%0d r%b exp v0 d00 g3 r0000", out_valid, out_data, grant_id, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_restart got %b exp 0001", req_ready); end
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_unlock got %b exp 0010", req_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h40 || grant_id !== 2'd1) begin
            errors++; $display("FAIL mid_post got v%b d%h g%0d exp v1 d40 g1", out_valid, out_data, grant_id);
        end
        req_valid = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_drain_refill();
        test_lock();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
